// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage - instruction-fetch stage of the pipelined processor.
//
// This stage holds the program counter and the word-addressed instruction
// ROM, and drives the IF/ID pipeline register that the decode stage (id_main)
// reads.
//
// Priority on each clock edge, highest first:
//   reset > redirect > stall > advance
//
// Ports
//   clk          in   1   clock; all state updates on the rising edge
//   reset        in   1   asynchronous, active-high reset
//   stall        in   1   hold the PC and IF/ID (driven by the hazard unit)
//   redirect     in   1   load the PC from redirect_pc and flush IF/ID
//   redirect_pc  in   32  redirect target byte address (low 2 bits dropped)
//   pc_out       out  32  current PC
//   if_id_instr  out  32  fetched instruction passed to decode
//   if_id_pc     out  32  PC of if_id_instr
//   if_id_pc4    out  32  if_id_pc + 4
//   if_id_valid  out  1   if_id_instr is a real fetched instruction
//   fetch_count  out  32  number of advance edges (only with FETCH_PERF_EN)
//
// Optional feature
//   Define the macro FETCH_PERF_EN to add the fetch_count port and its
//   counter. Without it, the port is absent; all other behaviour is the same.
// ---------------------------------------------------------------------------

// Program counter register.
// A redirect overrides a stall. PC arithmetic wraps modulo 2^32.
module fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] out
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= RESET_PC;
    end else if (redirect) begin
      // A misaligned target is silently word-aligned.
      out <= redirect_pc & ~32'h3;
    end else if (!stall) begin
      out <= out + 32'd4;
    end
  end

endmodule

// Word-addressed instruction ROM with a combinational read.
// Its contents are loaded from outside the design (by the test bench).
module fetch_rom #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       data
);

  logic [31:0] block [0:DEPTH-1];

  assign data = block[addr];

endmodule

module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
`ifdef FETCH_PERF_EN
  output logic [31:0] fetch_count,
`endif
  output logic        if_id_valid
);

  localparam int ADDR_W = $clog2(IMEM_DEPTH);

  logic [31:0]       pc;
  logic [31:0]       fetched_instr;
  logic [ADDR_W-1:0] rom_idx;
  logic              advance;

  // The PC bits above the ROM range are ignored, so fetches wrap modulo
  // the ROM depth.
  assign rom_idx = pc[ADDR_W+1:2];
  assign advance = !redirect && !stall;
  assign pc_out  = pc;

  fetch_pc #(
    .RESET_PC (RESET_PC)
  ) program_counter (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out         (pc)
  );

  fetch_rom #(
    .DEPTH  (IMEM_DEPTH),
    .ADDR_W (ADDR_W)
  ) instr_memory (
    .addr (rom_idx),
    .data (fetched_instr)
  );

  // IF/ID pipeline register.
  // A redirect flushes the slot to a NOP with a zero PC. A stall holds
  // every field unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= 32'h0;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
    end else if (redirect) begin
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= 32'h0;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if_id_instr <= fetched_instr;
      if_id_pc    <= pc;
      if_id_pc4   <= pc + 32'd4;
      if_id_valid <= 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  // Counts only the edges that load a valid instruction into IF/ID.
  // The counter wraps at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= 32'h0;
    end else if (advance) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`else
  // Without the performance counter, the advance term has no consumer.
  logic unused_advance;
  assign unused_advance = advance;
`endif

endmodule
